// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed 7-segment driver: saturating binary-to-BCD conversion (double dabble),
// leading-zero blanking, per-digit decimal points and a digit scan paced by the divided scan clock.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 1000,
  parameter int SEL_W    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_scan_clk,
  input  logic [13:0] i_value,
  input  logic [3:0]  i_dp_mask,
  input  logic        i_blank_lz,
  output logic [7:0]  o_seg,
  output logic [3:0]  o_com
);

  localparam int              PRE_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(SCAN_DIV - 1);
  localparam logic [13:0]     VALUE_MAX = 14'd9999;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state, next_state;
  logic             s1, s2, s3;
  logic             scan_tick;
  logic [PRE_W-1:0] prescale;
  logic [SEL_W-1:0] idx;
  logic [13:0]      bin;
  logic [15:0]      bcd, bcd_adj;
  logic [3:0]       shift_cnt;
  logic [13:0]      last_value;
  logic             force_conv;
  logic [15:0]      disp;
  logic             load_en, shift_en, done_en;
  logic [3:0]       digit;
  logic             blank;
  logic [6:0]       seg7;

  // The scan clock is foreign to i_clk, so it is synchronized before its rising edge is detected.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_scan_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign scan_tick = s2 & ~s3;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prescale <= '0;
      idx      <= '0;
    end else if (scan_tick) begin
      if (prescale == PRE_MAX) begin
        prescale <= '0;
        idx      <= idx + 1'b1;
      end else begin
        prescale <= prescale + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (force_conv || (i_value != last_value)) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (shift_cnt == 4'd13) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_en  = 1'b0;
    shift_en = 1'b0;
    done_en  = 1'b0;
    case (state)
      LOAD:    load_en  = 1'b1;
      SHIFT:   shift_en = 1'b1;
      DONE:    done_en  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // The raw input is kept as the last converted value so a held out-of-range value does not retrigger.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bin        <= '0;
      bcd        <= '0;
      shift_cnt  <= '0;
      last_value <= '0;
      force_conv <= 1'b1;
      disp       <= '0;
    end else begin
      if (load_en) begin
        bin        <= (i_value > VALUE_MAX) ? VALUE_MAX : i_value;
        last_value <= i_value;
        force_conv <= 1'b0;
        bcd        <= '0;
        shift_cnt  <= '0;
      end
      if (shift_en) begin
        bcd       <= {bcd_adj[14:0], bin[13]};
        bin       <= {bin[12:0], 1'b0};
        shift_cnt <= shift_cnt + 1'b1;
      end
      if (done_en) disp <= bcd;
    end
  end

  always_comb begin
    digit = disp[{idx, 2'b00} +: 4];
    case (idx)
      2'd1:    blank = i_blank_lz && (disp[15:4] == 12'd0);
      2'd2:    blank = i_blank_lz && (disp[15:8] == 8'd0);
      2'd3:    blank = i_blank_lz && (disp[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    case (digit)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
    if (blank) seg7 = 7'h7F;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_seg <= 8'hFF;
      o_com <= 4'b1111;
    end else begin
      o_seg <= {~i_dp_mask[idx], seg7};
      o_com <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller: per-cycle comparison against a behavioural display model
// plus literal digit checks for the documented scenarios.
module tb_fnd_scan_controller;

  localparam int SCAN_DIV = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_scan_clk;
  logic [13:0] i_value;
  logic [3:0]  i_dp_mask;
  logic        i_blank_lz;
  logic [7:0]  o_seg;
  logic [3:0]  o_com;

  int checks   = 0;
  int failures = 0;
  bit scan_random = 0;

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV), .SEL_W(2)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_scan_clk (i_scan_clk),
    .i_value    (i_value),
    .i_dp_mask  (i_dp_mask),
    .i_blank_lz (i_blank_lz),
    .o_seg      (o_seg),
    .o_com      (o_com)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_output(input string name, input logic [7:0] got_seg, input logic [3:0] got_com,
                              input logic [7:0] exp_seg, input logic [3:0] exp_com);
    checks++;
    if (got_seg !== exp_seg || got_com !== exp_com) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got seg=%h com=%b, expected seg=%h com=%b",
               name, $time, got_seg, got_com, exp_seg, exp_com);
    end
  endtask

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;  4: return 7'h19;
      5: return 7'h12;  6: return 7'h02;  7: return 7'h78;  8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  // Digit k of a decimal value, blanked when the value has no significant digit at or above position k.
  function automatic logic [7:0] expect_seg(input int value, input int k, input logic [3:0] dp, input logic blz);
    int pow;
    logic [6:0] s;
    pow = 1;
    for (int i = 0; i < k; i++) pow = pow * 10;
    if (blz && k > 0 && value < pow) s = 7'h7F;
    else                             s = seg_code((value / pow) % 10);
    return {~dp[k], s};
  endfunction

  // Behavioural model: scan position from the count of scan-clock rising edges, display value from a
  // conversion scheduled by edge number.
  logic [7:0]  exp_seg;
  logic [3:0]  exp_com;
  int          edge_n, ready_edge, capture_edge, done_edge, tick_total, disp_val, k;
  bit          model_force;
  logic [13:0] last_val, captured;
  bit          hist[$];

  always @(posedge i_clk) begin
    if (i_reset) begin
      edge_n = 0; ready_edge = 1; capture_edge = 0; done_edge = 0;
      tick_total = 0; disp_val = 0; model_force = 1; last_val = '0; captured = '0;
      hist = '{0, 0, 0};
      exp_seg = 8'hFF;
      exp_com = 4'b1111;
    end else begin
      edge_n++;
      k = (tick_total / SCAN_DIV) % 4;
      exp_com = 4'b1111;
      exp_com[k] = 1'b0;
      exp_seg = expect_seg(disp_val, k, i_dp_mask, i_blank_lz);
      if (hist[$-1] && !hist[$-2]) tick_total++;
      hist.push_back(i_scan_clk);
      if (hist.size() > 4) void'(hist.pop_front());
      if (edge_n == capture_edge) begin
        captured    = i_value;
        last_val    = i_value;
        model_force = 0;
      end
      if (edge_n == done_edge) disp_val = (captured > 14'd9999) ? 9999 : int'(captured);
      if (edge_n >= ready_edge && (model_force || i_value != last_val)) begin
        capture_edge = edge_n + 1;
        done_edge    = edge_n + 16;
        ready_edge   = edge_n + 17;
      end
    end
    #1;
    check_output("cycle", o_seg, o_com, exp_seg, exp_com);
  end

  initial begin
    int hp;
    i_scan_clk = 1'b0;
    forever begin
      hp = scan_random ? int'($urandom_range(1, 12)) : 10;
      repeat (hp) @(negedge i_clk);
      i_scan_clk = ~i_scan_clk;
    end
  end

  task automatic apply_stimulus(input logic [13:0] value, input logic [3:0] dp, input logic blz, input int cycles);
    @(negedge i_clk);
    i_value    = value;
    i_dp_mask  = dp;
    i_blank_lz = blz;
    repeat (cycles) @(negedge i_clk);
  endtask

  task automatic wait_digit(input logic [3:0] com, input logic [7:0] seg, input string name);
    int n;
    n = 0;
    do begin
      @(posedge i_clk);
      #1;
      n++;
    end while (o_com !== com && n < 400);
    check_output(name, o_seg, o_com, seg, com);
  endtask

  initial begin
    logic [13:0] rv;
    i_reset    = 1'b1;
    i_value    = '0;
    i_dp_mask  = '0;
    i_blank_lz = 1'b0;
    repeat (3) @(negedge i_clk);
    check_output("reset_hold", o_seg, o_com, 8'hFF, 4'b1111);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    check_output("first_digit", o_seg, o_com, 8'hC0, 4'b1110);

    apply_stimulus(14'd1234, 4'b0000, 1'b0, 40);
    wait_digit(4'b1110, 8'h99, "v1234_d0");
    wait_digit(4'b1101, 8'hB0, "v1234_d1");
    wait_digit(4'b1011, 8'hA4, "v1234_d2");
    wait_digit(4'b0111, 8'hF9, "v1234_d3");

    apply_stimulus(14'd12345, 4'b0000, 1'b0, 40);
    for (int d = 0; d < 4; d++) wait_digit(~(4'b0001 << d), 8'h90, "sat_12345");
    apply_stimulus(14'd10000, 4'b0000, 1'b0, 40);
    for (int d = 0; d < 4; d++) wait_digit(~(4'b0001 << d), 8'h90, "sat_10000");

    apply_stimulus(14'd7, 4'b0010, 1'b1, 40);
    wait_digit(4'b1110, 8'hF8, "lz_d0");
    wait_digit(4'b1101, 8'h7F, "lz_d1_dp");
    wait_digit(4'b1011, 8'hFF, "lz_d2");
    wait_digit(4'b0111, 8'hFF, "lz_d3");
    apply_stimulus(14'd7, 4'b0010, 1'b0, 2);
    wait_digit(4'b1110, 8'hF8, "nolz_d0");
    wait_digit(4'b1101, 8'h40, "nolz_d1_dp");
    wait_digit(4'b1011, 8'hC0, "nolz_d2");
    wait_digit(4'b0111, 8'hC0, "nolz_d3");

    apply_stimulus(14'd1234, 4'b0000, 1'b0, 5);
    apply_stimulus(14'd5678, 4'b0000, 1'b0, 40);
    wait_digit(4'b0111, 8'h92, "late_d3");
    wait_digit(4'b1110, 8'h80, "late_d0");
    wait_digit(4'b1011, 8'h82, "late_d2");

    apply_stimulus(14'd4321, 4'b0000, 1'b0, 6);
    i_reset = 1'b1;
    #1;
    check_output("reset_mid_shift", o_seg, o_com, 8'hFF, 4'b1111);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    check_output("restart_d0", o_seg, o_com, 8'hC0, 4'b1110);
    wait_digit(4'b0111, 8'h99, "reconv_d3");

    scan_random = 1;
    repeat (40) begin
      case ($urandom_range(0, 3))
        0:       rv = 14'($urandom_range(0, 16383));
        1:       rv = ($urandom_range(0, 1) == 0) ? 14'd9999 : 14'd10000;
        2:       rv = 14'($urandom_range(0, 99));
        default: rv = 14'($urandom_range(0, 9999));
      endcase
      if ($urandom_range(0, 11) == 0) begin
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
      end
      apply_stimulus(rv, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 50)));
    end
    repeat (60) @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
